// File: rtl/policy_deck_shuffler_if.sv
// Handshake bundle between the game core and the policy deck shuffler.
// The core is the master: it drives seed/start/deck and reads back the result.
interface policy_deck_shuffler_if #(
  parameter int W = 17
);
  logic         seed_load;
  logic [15:0]  seed;
  logic         start;
  logic [4:0]   n_cards;
  logic [W-1:0] deck_in;
  logic         busy;
  logic         done;
  logic [W-1:0] deck_out;

  modport master (
    output seed_load, seed, start, n_cards, deck_in,
    input  busy, done, deck_out
  );

  modport slave (
    input  seed_load, seed, start, n_cards, deck_in,
    output busy, done, deck_out
  );
endinterface

// File: rtl/policy_deck_shuffler.sv
// In-place Fisher-Yates shuffle of the low n_cards policy bits,
// driven by a free-running 16-bit LFSR with rejection sampling.
module policy_deck_shuffler #(
  parameter int          W         = 17,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic             clk,
  input logic             rst_n,
  policy_deck_shuffler_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t       state;
  logic [15:0]  lfsr;
  logic [15:0]  lfsr_step;
  logic [15:0]  seed_fix;
  logic [4:0]   i;
  logic [4:0]   n_eff;
  logic [4:0]   mask;
  logic [4:0]   r;
  logic         accept;
  logic         bit_i;
  logic         bit_r;
  logic [W-1:0] deck;
  logic [W-1:0] swapped;
  logic         busy_q;
  logic         done_q;

  assign lfsr_step = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign seed_fix  = (bus.seed == 16'h0) ? LFSR_SEED : bus.seed;
  assign n_eff     = (bus.n_cards > 5'(W)) ? 5'(W) : bus.n_cards;

  // Smallest all-ones mask covering i keeps rejection below one half.
  always_comb begin
    mask = 5'h01;
    unique case (1'b1)
      i[4]:                   mask = 5'h1f;
      (i[4:3] == 2'b01):      mask = 5'h0f;
      (i[4:2] == 3'b001):     mask = 5'h07;
      (i[4:1] == 4'b0001):    mask = 5'h03;
      default:                mask = 5'h01;
    endcase
  end

  assign r      = lfsr[4:0] & mask;
  assign accept = (r <= i);

  always_comb begin
    bit_i   = 1'b0;
    bit_r   = 1'b0;
    swapped = deck;
    for (int k = 0; k < W; k++) begin
      if (5'(k) == i) bit_i = deck[k];
      if (5'(k) == r) bit_r = deck[k];
    end
    for (int k = 0; k < W; k++) begin
      if (5'(k) == i)      swapped[k] = bit_r;
      else if (5'(k) == r) swapped[k] = bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      lfsr   <= LFSR_SEED;
      i      <= '0;
      deck   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lfsr   <= lfsr_step;
      unique case (state)
        S_IDLE: begin
          if (bus.seed_load) lfsr <= seed_fix;
          if (bus.start) begin
            deck <= bus.deck_in;
            if (n_eff <= 5'd1) begin
              done_q <= 1'b1;
            end else begin
              i      <= n_eff - 5'd1;
              state  <= S_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            deck <= swapped;
            i    <= i - 5'd1;
            if (i == 5'd1) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.deck_out = deck;

endmodule
